// File: rtl/ipbus_reg_bank.sv
// IPbus slave register bank: N_REGS registers, optional read-only status slots, optional wait states.
// The response (ack/err/rdata) and any register write happen on the edge that leaves RESP.

module ipbus_reg_slot #(
  parameter int DATA_W = 32,
  parameter bit RO     = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] status_i,
  output logic [DATA_W-1:0] rd_o,
  output logic [DATA_W-1:0] ctrl_o
);
  logic [DATA_W-1:0] val_q, val_d;

  always_comb val_d = (we_i && !RO) ? wdata_i : val_q;

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) val_q <= '0;
    else          val_q <= val_d;

  // Read-only slots expose live status and keep ctrl at zero; the flop folds away.
  assign rd_o   = RO ? status_i : val_q;
  assign ctrl_o = RO ? '0 : val_q;
endmodule

module ipbus_reg_bank #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                N_REGS      = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter logic [N_REGS-1:0] RO_MASK     = '0,
  parameter int                WAIT_STATES = 0
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [ADDR_W-1:0]        ipb_addr,
  input  logic [DATA_W-1:0]        ipb_wdata,
  input  logic                     ipb_strobe,
  input  logic                     ipb_write,
  output logic [DATA_W-1:0]        ipb_rdata,
  output logic                     ipb_ack,
  output logic                     ipb_err,
  input  logic [N_REGS*DATA_W-1:0] hw_status,
  output logic [N_REGS*DATA_W-1:0] ctrl_q
);
  localparam int IW = (N_REGS > 1) ? $clog2(N_REGS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                        state_q, state_d;
  logic [2:0]                    cnt_q, cnt_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic [DATA_W-1:0]             wdata_q, wdata_d;
  logic                          write_q, write_d;
  logic [DATA_W-1:0]             resp_q, resp_d;
  logic                          ack_q, ack_d, err_q, err_d;
  logic [DATA_W-1:0]             rdata_q, rdata_d;

  logic [N_REGS-1:0][DATA_W-1:0] slot_rd;
  logic [N_REGS-1:0]             slot_we;
  logic [ADDR_W-1:0]             dec_addr, dec_off;
  logic [IW-1:0]                 dec_idx;
  logic                          dec_hit, dec_ro, do_write;

  // In IDLE the address being latched this edge must drive the status sample.
  assign dec_addr = (state_q == S_IDLE) ? ipb_addr : addr_q;
  assign dec_off  = dec_addr - BASE_ADDR;
  assign dec_hit  = dec_off < ADDR_W'(N_REGS);
  assign dec_idx  = dec_off[IW-1:0];
  assign dec_ro   = dec_hit && RO_MASK[dec_idx];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    resp_d   = resp_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    do_write = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ipb_strobe) begin
          addr_d  = ipb_addr;
          wdata_d = ipb_wdata;
          write_d = ipb_write;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            resp_d  = slot_rd[dec_idx];
          end else begin
            state_d = S_WAIT;
            cnt_d   = 3'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (!ipb_strobe) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_RESP;
          resp_d  = slot_rd[dec_idx];
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (dec_hit && !(write_q && dec_ro)) begin
          ack_d    = 1'b1;
          rdata_d  = write_q ? '0 : resp_q;
          do_write = write_q;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      resp_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      resp_q  <= resp_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  generate
    for (genvar i = 0; i < N_REGS; i++) begin : g_slot
      assign slot_we[i] = do_write && (dec_idx == IW'(i));
      ipbus_reg_slot #(
        .DATA_W (DATA_W),
        .RO     (RO_MASK[i])
      ) u_slot (
        .clk_i    (CLK),
        .rst_n_i  (RST_N),
        .we_i     (slot_we[i]),
        .wdata_i  (wdata_q),
        .status_i (hw_status[i*DATA_W +: DATA_W]),
        .rd_o     (slot_rd[i]),
        .ctrl_o   (ctrl_q[i*DATA_W +: DATA_W])
      );
    end
  endgenerate

  assign ipb_ack   = ack_q;
  assign ipb_err   = err_q;
  assign ipb_rdata = rdata_q;
endmodule

// File: tb/tb_ipbus_reg_bank.sv
// Bench for ipbus_reg_bank: three configurations (defaults, BASE_ADDR=0x10, RO_MASK=0x02 + 3 wait states).
// Expected responses are queued when a transaction starts and checked when ack/err appears.
module tb_ipbus_reg_bank;
  localparam int DW = 32;
  localparam int NR = 8;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic [2:0]        strobe, write, ack, err;
  logic [31:0]       addr[3], wdata[3], rdata[3];
  logic [NR*DW-1:0]  hs[3], ctrl[3];

  always #5 CLK = ~CLK;

  ipbus_reg_bank u0 (
    .CLK(CLK), .RST_N(RST_N), .ipb_addr(addr[0]), .ipb_wdata(wdata[0]), .ipb_strobe(strobe[0]),
    .ipb_write(write[0]), .ipb_rdata(rdata[0]), .ipb_ack(ack[0]), .ipb_err(err[0]),
    .hw_status(hs[0]), .ctrl_q(ctrl[0]));

  ipbus_reg_bank #(.BASE_ADDR(32'h10)) u1 (
    .CLK(CLK), .RST_N(RST_N), .ipb_addr(addr[1]), .ipb_wdata(wdata[1]), .ipb_strobe(strobe[1]),
    .ipb_write(write[1]), .ipb_rdata(rdata[1]), .ipb_ack(ack[1]), .ipb_err(err[1]),
    .hw_status(hs[1]), .ctrl_q(ctrl[1]));

  ipbus_reg_bank #(.RO_MASK(8'h02), .WAIT_STATES(3)) u2 (
    .CLK(CLK), .RST_N(RST_N), .ipb_addr(addr[2]), .ipb_wdata(wdata[2]), .ipb_strobe(strobe[2]),
    .ipb_write(write[2]), .ipb_rdata(rdata[2]), .ipb_ack(ack[2]), .ipb_err(err[2]),
    .hw_status(hs[2]), .ctrl_q(ctrl[2]));

  typedef struct {
    int          d;
    bit          wr;
    logic [31:0] a;
    logic [31:0] wd;
    bit          ee;
    logic [31:0] er;
    bit          cr;
    int          lat;
  } vec_t;

  typedef struct {
    int          d;
    bit          ee;
    logic [31:0] er;
    bit          cr;
  } exp_t;

  int          n_vec = 0;
  int          n_fail = 0;
  exp_t        sbq[$];
  exp_t        mon_e;
  vec_t        vt[17];
  logic [31:0] b2b_val[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Response monitor: pops one expectation per ack/err pulse, checks idle outputs otherwise.
  always @(negedge CLK) begin
    if (RST_N) begin
      for (int d = 0; d < 3; d++) begin
        chk("ack_err_exclusive", 32'(ack[d] & err[d]), 32'h0);
        if (ack[d] || err[d]) begin
          if (sbq.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_resp: dut=%0d ack=%b err=%b", d, ack[d], err[d]);
          end else begin
            mon_e = sbq.pop_front();
            chk("resp_dut", 32'(d), 32'(mon_e.d));
            chk("resp_err", 32'(err[d]), 32'(mon_e.ee));
            if (mon_e.cr) chk("resp_rdata", rdata[d], mon_e.er);
          end
        end else begin
          chk("rdata_idle_zero", rdata[d], 32'h0);
        end
      end
    end
  end

  task automatic xact(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input bit ee, input logic [31:0] er, input bit cr, output int lat);
    exp_t e;
    @(negedge CLK);
    e.d = d; e.ee = ee; e.er = er; e.cr = cr;
    sbq.push_back(e);
    addr[d] = a; wdata[d] = wd; write[d] = wr; strobe[d] = 1'b1;
    lat = 0;
    while (lat < 30) begin
      @(posedge CLK); #1;
      lat++;
      if (ack[d] || err[d]) break;
      // Inputs other than strobe are don't-care once sampled.
      addr[d] = ~a; wdata[d] = ~wd; write[d] = ~wr;
    end
    strobe[d] = 1'b0;
    if (!(ack[d] || err[d])) begin
      n_vec++;
      n_fail++;
      $display("FAIL xact_timeout: dut=%0d addr=%h no response in 30 cycles", d, a);
      void'(sbq.pop_back());
    end
  endtask

  task automatic b2b();
    exp_t e;
    int   ack_t[4];
    int   i = 0;
    int   t = 0;
    e.d = 0; e.ee = 1'b0; e.er = '0; e.cr = 1'b0;
    @(negedge CLK);
    addr[0] = 32'd1; wdata[0] = b2b_val[0]; write[0] = 1'b1; strobe[0] = 1'b1;
    sbq.push_back(e);
    while (i < 4 && t < 40) begin
      @(posedge CLK); #1;
      t++;
      if (ack[0]) begin
        ack_t[i] = t;
        i++;
        if (i < 4) begin
          addr[0] = 32'(i + 1); wdata[0] = b2b_val[i];
          sbq.push_back(e);
        end else begin
          strobe[0] = 1'b0;
        end
      end
    end
    strobe[0] = 1'b0;
    if (i < 4) begin
      n_vec++;
      n_fail++;
      $display("FAIL b2b_timeout: got %0d acks expected 4", i);
    end else begin
      for (int k = 1; k < 4; k++) chk("b2b_ack_spacing", 32'(ack_t[k] - ack_t[k-1]), 32'd2);
    end
  endtask

  initial begin
    int lat;
    strobe = '0; write = '0;
    for (int d = 0; d < 3; d++) begin
      addr[d] = '0; wdata[d] = '0;
      hs[d] = {NR{32'hBAD0_0000 | 32'(d)}};
    end
    hs[2][1*DW +: DW] = 32'h1111_1111;
    b2b_val[0] = 32'hCCCC_CCCC; b2b_val[1] = 32'hECEC_ECEC;
    b2b_val[2] = 32'hAAAA_AAAA; b2b_val[3] = 32'h5555_5555;

    //        d  wr  addr   wdata         err  exp rdata     chk lat
    vt[0]  = '{0, 1, 32'h00, 32'hFFFFFFFF, 0, 32'h0,        0, 2};
    vt[1]  = '{0, 0, 32'h00, 32'h0,        0, 32'hFFFFFFFF, 1, 2};
    vt[2]  = '{0, 1, 32'h07, 32'hA5A5A5A5, 0, 32'h0,        0, 2};
    vt[3]  = '{0, 0, 32'h07, 32'h0,        0, 32'hA5A5A5A5, 1, 2};
    vt[4]  = '{0, 0, 32'h08, 32'h0,        1, 32'h0,        1, 2};
    vt[5]  = '{1, 0, 32'h0F, 32'h0,        1, 32'h0,        1, 2};
    vt[6]  = '{1, 0, 32'h18, 32'h0,        1, 32'h0,        1, 2};
    vt[7]  = '{1, 0, 32'h17, 32'h0,        0, 32'h0,        1, 2};
    vt[8]  = '{1, 1, 32'h12, 32'hDEADBEEF, 0, 32'h0,        0, 2};
    vt[9]  = '{1, 0, 32'h12, 32'h0,        0, 32'hDEADBEEF, 1, 2};
    vt[10] = '{1, 1, 32'h00, 32'h12345678, 1, 32'h0,        1, 2};
    vt[11] = '{2, 0, 32'h01, 32'h0,        0, 32'h11111111, 1, 5};
    vt[12] = '{2, 1, 32'h01, 32'h55555555, 1, 32'h0,        1, 5};
    vt[13] = '{2, 0, 32'h01, 32'h0,        0, 32'h11111111, 1, 5};
    vt[14] = '{2, 1, 32'h02, 32'h13572468, 0, 32'h0,        0, 5};
    vt[15] = '{2, 0, 32'h02, 32'h0,        0, 32'h13572468, 1, 5};
    vt[16] = '{2, 0, 32'h08, 32'h0,        1, 32'h0,        1, 5};

    repeat (3) @(negedge CLK);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    for (int d = 0; d < 3; d++) begin
      chk("rst_rdata", rdata[d], 32'h0);
      chk("rst_ctrl_nonzero", 32'(ctrl[d] != '0), 32'h0);
    end
    RST_N = 1'b1;

    for (int v = 0; v < 17; v++) begin
      xact(vt[v].d, vt[v].wr, vt[v].a, vt[v].wd, vt[v].ee, vt[v].er, vt[v].cr, lat);
      chk("latency", 32'(lat), 32'(vt[v].lat));
    end

    chk("ctrl0_slot0", ctrl[0][0*DW +: DW], 32'hFFFF_FFFF);
    chk("ctrl0_slot7", ctrl[0][7*DW +: DW], 32'hA5A5_A5A5);
    chk("ctrl1_slot2", ctrl[1][2*DW +: DW], 32'hDEAD_BEEF);
    chk("ctrl1_slot0_untouched", ctrl[1][0*DW +: DW], 32'h0);
    chk("ctrl2_ro_slot_zero", ctrl[2][1*DW +: DW], 32'h0);
    chk("ctrl2_slot2", ctrl[2][2*DW +: DW], 32'h1357_2468);

    b2b();
    for (int k = 0; k < 4; k++) begin
      xact(0, 1'b0, 32'(k + 1), 32'h0, 1'b0, b2b_val[k], 1'b1, lat);
      chk("ctrl0_b2b", ctrl[0][(k+1)*DW +: DW], b2b_val[k]);
    end

    // Abort: strobe low at the second edge after sampling.
    @(negedge CLK);
    addr[2] = 32'd3; wdata[2] = 32'h7777_7777; write[2] = 1'b1; strobe[2] = 1'b1;
    @(posedge CLK);
    @(posedge CLK); #1;
    strobe[2] = 1'b0;
    repeat (8) @(posedge CLK);
    #1;
    chk("abort_no_write", ctrl[2][3*DW +: DW], 32'h0);
    xact(2, 1'b0, 32'd3, 32'h0, 1'b0, 32'h0, 1'b1, lat);
    chk("abort_recovery_latency", 32'(lat), 32'd5);

    // Reset while u2 waits on a write and u0 is presenting a read ack.
    @(negedge CLK);
    addr[0] = 32'd0; write[0] = 1'b0; strobe[0] = 1'b1;
    addr[2] = 32'd5; wdata[2] = 32'hECEC_ECEC; write[2] = 1'b1; strobe[2] = 1'b1;
    @(posedge CLK);
    @(posedge CLK); #1;
    chk("pre_reset_ack0", 32'(ack[0]), 32'h1);
    RST_N = 1'b0;
    strobe = '0;
    #1;
    chk("async_rst_ack", 32'(ack), 32'h0);
    chk("async_rst_err", 32'(err), 32'h0);
    chk("async_rst_rdata0", rdata[0], 32'h0);
    chk("async_rst_ctrl0", ctrl[0][0*DW +: DW], 32'h0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (8) @(posedge CLK);
    #1;
    chk("post_reset_no_write", ctrl[2][5*DW +: DW], 32'h0);
    xact(2, 1'b1, 32'd5, 32'hECEC_ECEC, 1'b0, 32'h0, 1'b0, lat);
    xact(2, 1'b0, 32'd5, 32'h0, 1'b0, 32'hECEC_ECEC, 1'b1, lat);
    chk("post_reset_latency", 32'(lat), 32'd5);

    repeat (2) @(negedge CLK);
    chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
